// File: rtl/trees_vote_pack.sv
// trees_vote_pack
// Vote accumulation and prediction packing for the tree-ensemble accelerator.
// Leaf class values arrive N_LANES per beat on a valid/ready stream; votes are
// counted per class for each sample, the winning class (strict maximum, lowest
// index on ties) is found by a one-class-per-cycle scan, and the prediction is
// packed PRED_BITS wide into WORD_BITS-wide words read back by word address.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a burst (sampled only in IDLE)
//   burst_len       samples in the burst, captured with start, clamped to MAX_BURST
//   leaf_valid      leaf beat valid
//   leaf_ready      high in ACCUM; a beat is accepted when valid & ready
//   leaf_mask       per-lane vote enable
//   leaf_class      lane k class value at [32k +: 32]
//   leaf_last       accepted beat closes the current sample
//   pred_addr       readback word address
//   prediction      registered readback word (0 for out-of-range addresses)
//   busy            not IDLE
//   done            one-cycle pulse at burst end
module trees_vote_pack #(
  parameter int N_CLASSES = 32,
  parameter int N_LANES   = 4,
  parameter int N_TREES   = 128,
  parameter int MAX_BURST = 54,
  parameter int PRED_BITS = 8,
  parameter int WORD_BITS = 64,
  localparam int CNT_BITS       = $clog2(N_TREES + 1),
  localparam int MAX_BURST_BITS = $clog2(MAX_BURST + 1),
  localparam int PPW            = WORD_BITS / PRED_BITS,
  localparam int N_WORDS        = (MAX_BURST + PPW - 1) / PPW,
  localparam int ADDR_BITS      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [MAX_BURST_BITS-1:0] burst_len,
  input  logic                      leaf_valid,
  output logic                      leaf_ready,
  input  logic [N_LANES-1:0]        leaf_mask,
  input  logic [N_LANES*32-1:0]     leaf_class,
  input  logic                      leaf_last,
  input  logic [ADDR_BITS-1:0]      pred_addr,
  output logic [WORD_BITS-1:0]      prediction,
  output logic                      busy,
  output logic                      done
);

  localparam int CLS_BITS  = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
  localparam int LANE_BITS = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int SUM_BITS  = $clog2(N_LANES + 1);
  localparam int TOT_BITS  = CNT_BITS + SUM_BITS;

  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [TOT_BITS-1:0] TOT_ONE  = TOT_BITS'(1);
  localparam logic [CLS_BITS-1:0] CLS_LAST = CLS_BITS'(N_CLASSES - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, WRITE} state_e;

  state_e                    state_q;
  logic [CNT_BITS-1:0]       cnt_q [N_CLASSES];
  logic [CNT_BITS-1:0]       cnt_d [N_CLASSES];
  logic [MAX_BURST_BITS-1:0] len_q;
  logic [MAX_BURST_BITS-1:0] sample_idx_q;
  logic [MAX_BURST_BITS-1:0] burst_len_clamped;
  logic [CLS_BITS-1:0]       cls_q;
  logic [CLS_BITS-1:0]       best_q;
  logic [CNT_BITS-1:0]       best_cnt_q;
  logic [WORD_BITS-1:0]      mem_q [N_WORDS];
  logic [WORD_BITS-1:0]      prediction_q;
  logic                      busy_q;
  logic                      done_q;

  logic [ADDR_BITS-1:0]      wr_word;
  logic [LANE_BITS-1:0]      wr_lane;
  logic [WORD_BITS-1:0]      word_new;

  assign burst_len_clamped = (burst_len > MAX_BURST_BITS'(MAX_BURST)) ?
                             MAX_BURST_BITS'(MAX_BURST) : burst_len;
  assign wr_word = ADDR_BITS'(sample_idx_q / PPW);
  assign wr_lane = LANE_BITS'(sample_idx_q % PPW);

  assign leaf_ready = (state_q == ACCUM);
  assign prediction = prediction_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // Per-class next count for an accepted beat: current count plus the number
  // of enabled lanes carrying that class, saturated. Out-of-range class values
  // never match any c, so they drop out naturally.
  always_comb begin : vote_count
    logic [TOT_BITS-1:0] total;
    // NOTE: every combinational variable is assigned before any conditional
    // use, so no path leaves it holding an old value (no latch inferred).
    total = '0;
    for (int c = 0; c < N_CLASSES; c++) begin
      total = {{SUM_BITS{1'b0}}, cnt_q[c]};
      for (int k = 0; k < N_LANES; k++) begin
        if (leaf_mask[k] && (leaf_class[32*k +: 32] == 32'(c))) begin
          // NOTE: blocking assignments here because total is a running sum
          // within one evaluation, not state carried across clock edges.
          total = total + TOT_ONE;
        end
      end
      cnt_d[c] = (total > {{SUM_BITS{1'b0}}, CNT_MAX}) ? CNT_MAX : total[CNT_BITS-1:0];
    end
  end

  // Lane 0 starts a fresh word; later lanes merge into the stored word.
  always_comb begin : pack_word
    word_new = (wr_lane == '0) ? '0 : mem_q[wr_word];
    word_new[int'(wr_lane)*PRED_BITS +: PRED_BITS] = PRED_BITS'(best_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      sample_idx_q <= '0;
      cls_q        <= '0;
      best_q       <= '0;
      best_cnt_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      prediction_q <= '0;
      for (int c = 0; c < N_CLASSES; c++) cnt_q[c] <= '0;
      // NOTE: the word store is reset as well, because readback after reset
      // must return zero; it is small enough to live in flops.
      for (int w = 0; w < N_WORDS; w++) mem_q[w] <= '0;
    end else begin
      done_q       <= 1'b0;
      prediction_q <= (int'(pred_addr) < N_WORDS) ? mem_q[pred_addr] : '0;

      unique case (state_q)
        IDLE: begin
          if (start) begin
            len_q        <= burst_len_clamped;
            sample_idx_q <= '0;
            for (int c = 0; c < N_CLASSES; c++) cnt_q[c] <= '0;
            if (burst_len_clamped == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= ACCUM;
              busy_q  <= 1'b1;
            end
          end
        end

        ACCUM: begin
          if (leaf_valid) begin
            for (int c = 0; c < N_CLASSES; c++) cnt_q[c] <= cnt_d[c];
            if (leaf_last) begin
              state_q <= ARGMAX;
              cls_q   <= '0;
            end
          end
        end

        // Class 0 seeds the running best; later classes win only on a strictly
        // larger count, which keeps ties at the lowest index.
        ARGMAX: begin
          if ((cls_q == '0) || (cnt_q[cls_q] > best_cnt_q)) begin
            best_q     <= cls_q;
            best_cnt_q <= cnt_q[cls_q];
          end
          if (cls_q == CLS_LAST) state_q <= WRITE;
          else                   cls_q   <= cls_q + 1'b1;
        end

        WRITE: begin
          mem_q[wr_word] <= word_new;
          for (int c = 0; c < N_CLASSES; c++) cnt_q[c] <= '0;
          sample_idx_q <= sample_idx_q + 1'b1;
          if ((sample_idx_q + 1'b1) == len_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ACCUM;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trees_vote_pack.sv
// Testbench for trees_vote_pack (default parameters). A behavioural model keeps
// per-class vote tallies in an int array and the packed store as a flat byte
// array; the bench drives directed and $urandom stimulus and compares
// handshake, timing and readback against it.
module tb_trees_vote_pack;

  localparam int NC  = 32;
  localparam int PPW = 8;
  localparam int NW  = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [5:0]   burst_len;
  logic         leaf_valid;
  logic         leaf_ready;
  logic [3:0]   leaf_mask;
  logic [127:0] leaf_class;
  logic         leaf_last;
  logic [2:0]   pred_addr;
  logic [63:0]  prediction;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  trees_vote_pack dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .burst_len  (burst_len),
    .leaf_valid (leaf_valid),
    .leaf_ready (leaf_ready),
    .leaf_mask  (leaf_mask),
    .leaf_class (leaf_class),
    .leaf_last  (leaf_last),
    .pred_addr  (pred_addr),
    .prediction (prediction),
    .busy       (busy),
    .done       (done)
  );

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;

  // Counts done pulses (each pulse is one cycle wide).
  always @(posedge clk) if (done === 1'b1) done_cnt++;

  // ---------------- behavioural model ----------------
  int         model_votes [NC];
  logic [7:0] model_bytes [NW*PPW];

  function automatic void model_clear_votes();
    for (int c = 0; c < NC; c++) model_votes[c] = 0;
  endfunction

  function automatic void model_clear_store();
    for (int i = 0; i < NW*PPW; i++) model_bytes[i] = 8'h00;
  endfunction

  function automatic int model_argmax();
    int b = 0;
    for (int c = 1; c < NC; c++) if (model_votes[c] > model_votes[b]) b = c;
    return b;
  endfunction

  function automatic void model_store(input int idx, input int cls);
    if (idx % PPW == 0) for (int j = 0; j < PPW; j++) model_bytes[idx + j] = 8'h00;
    model_bytes[idx] = 8'(cls);
  endfunction

  function automatic logic [63:0] model_word(input int w);
    logic [63:0] v;
    for (int j = 0; j < PPW; j++) v[8*j +: 8] = model_bytes[w*PPW + j];
    return v;
  endfunction

  function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  // ---------------- stimulus helpers (all start and end at a negedge) ----------------
  task automatic start_burst(input int len);
    burst_len = 6'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] cls, input logic [3:0] msk,
                           input logic last, output bit ok);
    int v;
    leaf_class = cls; leaf_mask = msk; leaf_last = last; leaf_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (leaf_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      for (int k = 0; k < 4; k++) begin
        v = int'(cls[32*k +: 32]);
        if (msk[k] && v >= 0 && v < NC && model_votes[v] < 255) model_votes[v]++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    leaf_valid = 1'b0; leaf_last = 1'b0; leaf_mask = '0;
  endtask

  task automatic one_beat_sample(input int idx, input logic [127:0] cls,
                                 input logic [3:0] msk, output bit ok);
    model_clear_votes();
    send_beat(cls, msk, 1'b1, ok);
    model_store(idx, model_argmax());
  endtask

  // n = number of clock edges after the accepting edge until done is seen; -1 on timeout.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic read_word(input int a, output logic [63:0] v);
    pred_addr = 3'(a);
    @(negedge clk);
    v = prediction;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [63:0] v;
    rst = 1'b1; start = 1'b0; burst_len = '0; leaf_valid = 1'b0; leaf_mask = '0;
    leaf_class = '0; leaf_last = 1'b0; pred_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear_store();
    n_vec++; if (leaf_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0", leaf_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
    n_vec++; if (prediction !== 64'h0) begin n_err++; $display("FAIL reset_pred got %h exp 0", prediction); end
    read_word(0, v);
    n_vec++; if (v !== 64'h0) begin n_err++; $display("FAIL reset_word0 got %h exp 0", v); end
  endtask

  task automatic test_single();
    bit ok; int n; logic [63:0] v;
    start_burst(1);
    n_vec++; if (busy !== 1'b1 || leaf_ready !== 1'b1) begin n_err++; $display("FAIL single_accum got busy=%b ready=%b exp 1 1", busy, leaf_ready); end
    one_beat_sample(0, pack4(3, 3, 5, 7), 4'b1111, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL single_accept got timeout exp accept"); end
    wait_done(n);
    // accept edge + 32 ARGMAX + 1 WRITE: done is seen 33 edges after the accept
    n_vec++; if (n !== NC + 1) begin n_err++; $display("FAIL single_latency got %0d exp %0d", n, NC + 1); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_at_done got %b exp 0", busy); end
    @(negedge clk);
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL single_done_width got %b exp 0", done); end
    read_word(0, v);
    n_vec++; if (v !== 64'h3 || v !== model_word(0)) begin n_err++; $display("FAIL single_word0 got %h exp %h", v, model_word(0)); end
  endtask

  task automatic test_tie();
    bit ok, ok2, ok3; int n; logic [63:0] v;
    start_burst(1);
    model_clear_votes();
    send_beat(pack4(9, 4, 9, 4), 4'b1111, 1'b0, ok);
    send_beat(pack4(9, 4, 9, 4), 4'b1111, 1'b0, ok2);
    send_beat(pack4(1, 1, 1, 1), 4'b0000, 1'b1, ok3);   // empty last beat
    model_store(0, model_argmax());
    wait_done(n);
    n_vec++; if (!(ok && ok2 && ok3) || n < 0) begin n_err++; $display("FAIL tie_handshake got ok=%b%b%b n=%0d exp accepts", ok, ok2, ok3, n); end
    read_word(0, v);
    n_vec++; if (v !== 64'h4 || v !== model_word(0)) begin n_err++; $display("FAIL tie_low got %h exp %h", v, model_word(0)); end
    start_burst(1);
    one_beat_sample(0, pack4(9, 9, 4, 20), 4'b1111, ok);
    wait_done(n);
    read_word(0, v);
    n_vec++; if (v !== 64'h9 || v !== model_word(0)) begin n_err++; $display("FAIL tie_max got %h exp %h", v, model_word(0)); end
  endtask

  task automatic test_ignored();
    bit ok, ok2; int n; logic [63:0] v;
    start_burst(1);
    model_clear_votes();
    send_beat(pack4(40, 2, 2, 2), 4'b0001, 1'b0, ok);
    send_beat(pack4(0, 0, 0, 0), 4'b0000, 1'b1, ok2);
    model_store(0, model_argmax());
    wait_done(n);
    read_word(0, v);
    n_vec++; if (v !== 64'h0 || v !== model_word(0) || n < 0) begin n_err++; $display("FAIL ignored_votes got %h exp %h", v, model_word(0)); end
  endtask

  task automatic test_packing();
    bit ok; bit all_ok; int n; logic [63:0] v;
    all_ok = 1'b1;
    start_burst(10);
    for (int i = 0; i < 10; i++) begin
      one_beat_sample(i, pack4(i, i, i, i), 4'b1111, ok);
      all_ok &= ok;
    end
    wait_done(n);
    n_vec++; if (!all_ok || n !== NC + 1) begin n_err++; $display("FAIL pack_burst got ok=%b n=%0d exp 1 %0d", all_ok, n, NC + 1); end
    read_word(0, v);
    n_vec++; if (v !== 64'h0706050403020100 || v !== model_word(0)) begin n_err++; $display("FAIL pack_word0 got %h exp %h", v, model_word(0)); end
    read_word(1, v);
    n_vec++; if (v !== 64'h0000000000000908 || v !== model_word(1)) begin n_err++; $display("FAIL pack_word1 got %h exp %h", v, model_word(1)); end
    start_burst(1);
    one_beat_sample(0, pack4(31, 31, 31, 31), 4'b1111, ok);
    wait_done(n);
    read_word(0, v);
    n_vec++; if (v !== 64'h1F || v !== model_word(0)) begin n_err++; $display("FAIL pack_rewrite0 got %h exp %h", v, model_word(0)); end
    read_word(1, v);
    n_vec++; if (v !== 64'h0908 || v !== model_word(1)) begin n_err++; $display("FAIL pack_keep1 got %h exp %h", v, model_word(1)); end
  endtask

  task automatic test_zero_len();
    int d0;
    d0 = done_cnt;
    start_burst(0);
    n_vec++; if (done !== 1'b1 || busy !== 1'b0 || leaf_ready !== 1'b0) begin n_err++; $display("FAIL zero_len got done=%b busy=%b ready=%b exp 1 0 0", done, busy, leaf_ready); end
    @(negedge clk);
    n_vec++; if (done !== 1'b0 || leaf_ready !== 1'b0 || done_cnt !== d0 + 1) begin n_err++; $display("FAIL zero_len_after got done=%b ready=%b pulses=%0d exp 0 0 %0d", done, leaf_ready, done_cnt - d0, 1); end
  endtask

  task automatic test_start_ignored();
    bit ok, ok2; int n, d0;
    d0 = done_cnt;
    start_burst(2);
    start_burst(1);          // arrives in ACCUM: must be ignored
    one_beat_sample(0, pack4(5, 6, 6, 0), 4'b1111, ok);
    one_beat_sample(1, pack4(11, 11, 2, 2), 4'b1110, ok2);
    n_vec++; if (!(ok && ok2) || done_cnt !== d0) begin n_err++; $display("FAIL start_ignored got ok=%b%b pulses=%0d exp 11 0", ok, ok2, done_cnt - d0); end
    wait_done(n);
    n_vec++; if (n !== NC + 1) begin n_err++; $display("FAIL start_ignored_done got %0d exp %0d", n, NC + 1); end
  endtask

  task automatic test_clamp();
    bit ok; bit all_ok; int n, d0; logic [63:0] v;
    all_ok = 1'b1;
    d0 = done_cnt;
    start_burst(60);
    for (int i = 0; i < 54; i++) begin
      one_beat_sample(i, pack4($urandom_range(0, 35), $urandom_range(0, 35),
                               $urandom_range(0, 35), $urandom_range(0, 7)),
                      4'($urandom_range(0, 15)), ok);
      all_ok &= ok;
    end
    wait_done(n);
    n_vec++; if (!all_ok || n !== NC + 1 || done_cnt !== d0 + 1) begin n_err++; $display("FAIL clamp_done got ok=%b n=%0d pulses=%0d exp 1 %0d 1", all_ok, n, done_cnt - d0, NC + 1); end
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0 || leaf_ready !== 1'b0) begin n_err++; $display("FAIL clamp_idle got busy=%b ready=%b exp 0 0", busy, leaf_ready); end
    for (int w = 0; w < NW; w++) begin
      read_word(w, v);
      n_vec++; if (v !== model_word(w)) begin n_err++; $display("FAIL clamp_word%0d got %h exp %h", w, v, model_word(w)); end
    end
  endtask

  task automatic test_reset_mid_argmax();
    bit ok; int n, d0; logic [63:0] v;
    start_burst(3);
    model_clear_votes();
    send_beat(pack4(12, 12, 12, 12), 4'b1111, 1'b1, ok);
    repeat (5) @(negedge clk);
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear_store();
    n_vec++; if (busy !== 1'b0 || leaf_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid got busy=%b ready=%b exp 0 0", busy, leaf_ready); end
    for (int w = 0; w < NW; w++) begin
      read_word(w, v);
      n_vec++; if (v !== model_word(w)) begin n_err++; $display("FAIL rst_word%0d got %h exp %h", w, v, model_word(w)); end
    end
    repeat (40) @(negedge clk);
    n_vec++; if (done_cnt !== d0) begin n_err++; $display("FAIL rst_no_done got %0d pulses exp 0", done_cnt - d0); end
    start_burst(1);
    one_beat_sample(0, pack4(6, 6, 6, 1), 4'b1111, ok);
    wait_done(n);
    read_word(0, v);
    n_vec++; if (!ok || n !== NC + 1 || v !== 64'h6 || v !== model_word(0)) begin n_err++; $display("FAIL rst_fresh got n=%0d word=%h exp %0d %h", n, v, NC + 1, model_word(0)); end
  endtask

  task automatic test_random();
    bit ok; bit all_ok; int n, len, nb, cls[4]; logic [63:0] v;
    for (int b = 0; b < 4; b++) begin
      all_ok = 1'b1;
      len = $urandom_range(1, 12);
      start_burst(len);
      for (int s = 0; s < len; s++) begin
        model_clear_votes();
        nb = $urandom_range(1, 3);
        for (int j = 0; j < nb; j++) begin
          for (int k = 0; k < 4; k++)
            cls[k] = ($urandom_range(0, 5) == 0) ? 32 + $urandom_range(0, 10) : $urandom_range(0, 9);
          send_beat(pack4(cls[0], cls[1], cls[2], cls[3]), 4'($urandom_range(0, 15)),
                    (j == nb - 1), ok);
          all_ok &= ok;
        end
        model_store(s, model_argmax());
      end
      wait_done(n);
      n_vec++; if (!all_ok || n !== NC + 1) begin n_err++; $display("FAIL rand%0d_done got ok=%b n=%0d exp 1 %0d", b, all_ok, n, NC + 1); end
      for (int w = 0; w < NW; w++) begin
        read_word(w, v);
        n_vec++; if (v !== model_word(w)) begin n_err++; $display("FAIL rand%0d_word%0d got %h exp %h", b, w, v, model_word(w)); end
      end
      read_word(7, v);
      n_vec++; if (v !== 64'h0) begin n_err++; $display("FAIL rand%0d_oob got %h exp 0", b, v); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_ignored();
    test_packing();
    test_zero_len();
    test_start_ignored();
    test_clamp();
    test_reset_mid_argmax();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
